// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer.
// Holds the trace record layout (width and field offsets), the pending-stage
// struct, and a helper that packs the record fields into one flat vector.
package commit_trace_buffer_pkg;

    localparam int SEQ_W       = 16;
    localparam int PC_W        = 32;
    localparam int INSTR_W     = 32;
    localparam int TRACE_REC_W = 81;  // 32 pc + 32 instr + 1 mispred + 16 seq

    // Record layout, LSB first: seq, mispred, instr, pc.
    localparam int REC_SEQ_LSB     = 0;
    localparam int REC_MISPRED_BIT = 16;
    localparam int REC_INSTR_LSB   = 17;
    localparam int REC_PC_LSB      = 49;

    // An instruction that has retired but still waits for its successor.
    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pred_pc;
        logic [SEQ_W-1:0]   seq;
    } pend_t;

    function automatic logic [TRACE_REC_W-1:0] pack_rec(
        input logic [PC_W-1:0]    pc,
        input logic [INSTR_W-1:0] instr,
        input logic               mispred,
        input logic [SEQ_W-1:0]   seq
    );
        return {pc, instr, mispred, seq};
    endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: DEPTH x W synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst        clock, async active-high reset (clears storage too)
//   push, push_data write one entry; caller only pushes when there is room
//                   (not full, or a pop in the same cycle)
//   pop             retire the head entry; caller only pops when not empty
//   head_data       head entry; while empty it shows the most recently
//                   popped entry (all zeros after reset)
//   full, empty     occupancy flags derived from the AW+1 bit pointers
//   count           registered occupancy (wr_ptr - rd_ptr)
module trace_fifo
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = TRACE_REC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic [AW-1:0] prev_idx;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ptr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

    // While empty the write slot equals the read slot, so the slot just
    // behind the read pointer still holds the last head and is never
    // overwritten until something is pushed again.
    assign prev_idx  = rd_ptr[AW-1:0] - AW'(1);
    assign head_data = empty ? mem[prev_idx] : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
            end
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: turns the CPU retirement interface into a stream of
// trace records, each flagged with whether its next-PC prediction matched
// the PC of the instruction that actually retired after it.
// Ports:
//   clk, rst                 clock, async active-high reset
//   commit_i, commit_*_i     retirement strobe and its pc / instr / pred_pc
//   flush_i                  emit the pending record without a successor
//   clear_i                  zero the three statistics counters
//   trace_*                  record stream (valid/ready), head fields
//   fifo_count_o             buffered record count
//   instret_o, mispred_cnt_o, drop_cnt_o   saturating statistics counters
//
// Stream handshake: a record transfers on any rising edge where
// trace_valid_o && trace_ready_i. trace_valid_o never depends on
// trace_ready_i, never drops without a transfer, and the head fields are
// held stable while valid is high and ready is low.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_i,
    input  logic [31:0]      commit_pc_i,
    input  logic [31:0]      commit_instr_i,
    input  logic [31:0]      commit_pred_pc_i,
    input  logic             flush_i,
    input  logic             clear_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [31:0]      trace_pc_o,
    output logic [31:0]      trace_instr_o,
    output logic             trace_mispred_o,
    output logic [15:0]      trace_seq_o,
    output logic [AW:0]      fifo_count_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    pend_t                  pend_q;
    logic [SEQ_W-1:0]       seq_ctr_q;

    logic                   push_req;
    logic                   rec_mispred;
    logic [TRACE_REC_W-1:0] push_rec;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;
    logic [TRACE_REC_W-1:0] head_rec;

    // A successor commit takes precedence over flush; the mispred flag only
    // has meaning when there is a successor to compare against.
    always_comb begin
        push_req    = pend_q.valid && (commit_i || flush_i);
        rec_mispred = commit_i && (pend_q.pred_pc != commit_pc_i);
        push_rec    = pack_rec(pend_q.pc, pend_q.instr, rec_mispred, pend_q.seq);
    end

    assign fifo_pop  = trace_valid_o && trace_ready_i;
    // Full with a simultaneous pop still has room: the freed slot is reused.
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            seq_ctr_q <= '0;
        end else if (commit_i) begin
            pend_q <= '{valid:   1'b1,
                        pc:      commit_pc_i,
                        instr:   commit_instr_i,
                        pred_pc: commit_pred_pc_i,
                        seq:     seq_ctr_q};
            seq_ctr_q <= seq_ctr_q + SEQ_W'(1);
        end else if (flush_i) begin
            pend_q.valid <= 1'b0;
        end
    end

    // Counters stick at all-ones; clear wins over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_o     <= '0;
            mispred_cnt_o <= '0;
            drop_cnt_o    <= '0;
        end else if (clear_i) begin
            instret_o     <= '0;
            mispred_cnt_o <= '0;
            drop_cnt_o    <= '0;
        end else begin
            if (commit_i && (instret_o != '1)) begin
                instret_o <= instret_o + CNT_W'(1);
            end
            // Counted at push time, so dropped mispredictions still count.
            if (push_req && rec_mispred && (mispred_cnt_o != '1)) begin
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            end
            if (drop && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .W    (TRACE_REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_rec),
        .pop      (fifo_pop),
        .head_data(head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count_o)
    );

    assign trace_valid_o   = !fifo_empty;
    assign trace_pc_o      = head_rec[REC_PC_LSB +: PC_W];
    assign trace_instr_o   = head_rec[REC_INSTR_LSB +: INSTR_W];
    assign trace_mispred_o = head_rec[REC_MISPRED_BIT];
    assign trace_seq_o     = head_rec[REC_SEQ_LSB +: SEQ_W];

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU top-level and consumes its retirement interface: commit strobe, commit PC, instruction word and predicted next PC.
- Pairs each retired instruction with the next one to decide whether its next-PC prediction was correct.
- Buffers the resulting records in a FIFO and drains them over a valid/ready trace stream.
- Maintains retired-instruction, misprediction and dropped-record counters for the test harness and performance reporting.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, ≥2)
- AW, 3, FIFO address width; log2(DEPTH)
- CNT_W, 32, width of each statistics counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- commit_i  input  1  one instruction retires this cycle
- commit_pc_i  input  32  PC of the retiring instruction
- commit_instr_i  input  32  instruction word of the retiring instruction
- commit_pred_pc_i  input  32  next PC predicted for the retiring instruction
- flush_i  input  1  push the pending record without a successor (end of run)
- clear_i  input  1  synchronous clear of all three counters
- trace_valid_o  output  1  head FIFO record is valid
- trace_ready_i  input  1  consumer accepts the head record
- trace_pc_o  output  32  head record PC
- trace_instr_o  output  32  head record instruction
- trace_mispred_o  output  1  head record next-PC prediction was wrong
- trace_seq_o  output  16  head record sequence number
- fifo_count_o  output  AW+1  occupied FIFO entries
- instret_o  output  CNT_W  retired-instruction count
- mispred_cnt_o  output  CNT_W  misprediction count
- drop_cnt_o  output  CNT_W  records lost because the FIFO was full

Behaviour:
- Reset (async, immediate):
  - All outputs 0; FIFO empty; pointers 0.
  - Pending register invalid; seq counter 0.
- Pending stage: one register {valid, pc, instr, pred_pc, seq}.
- On commit_i with pending valid:
  - Form record {pend.pc, pend.instr, mispred = (pend.pred_pc != commit_pc_i), pend.seq}.
  - Push the record; load the new commit into pending with seq = seq_ctr; seq_ctr += 1 (16-bit, wraps 0xFFFF→0).
- On commit_i with pending invalid: load pending only; no push.
- On flush_i with pending valid and no commit_i:
  - Push the pending record with mispred = 0; pending becomes invalid.
- commit_i and flush_i in the same cycle: commit rule applies; flush is ignored.
- instret_o increments on every commit_i.
- mispred_cnt_o increments on every push with mispred = 1.
- Counters saturate at all-ones and do not wrap.
- clear_i zeroes all three counters:
  - It has priority over any increment in the same cycle.
  - It does not affect the FIFO, pending register or seq_ctr.
- FIFO:
  - DEPTH entries; pointers are AW+1 bits.
  - full = pointers differ only in MSB; empty = pointers equal.
  - fifo_count_o = wr_ptr − rd_ptr, registered with the pointers.
- Pop occurs when trace_valid_o && trace_ready_i.
- Push acceptance: a push is accepted when not full, or when a pop happens in the same cycle.
  - Full + simultaneous pop + push: both occur; count stays at DEPTH.
- Push rejected (full, no pop):
  - Record discarded; drop_cnt_o += 1 (saturating).
  - mispred_cnt_o still counts the dropped record.
- Output stream:
  - First-word-fall-through from registered storage.
  - trace_valid_o = !empty, asserted the cycle after the first push.
  - Head fields stable while valid && !ready.
  - trace_valid_o never drops without a pop.
- Empty FIFO: trace_valid_o = 0; trace_ready_i is ignored; data outputs hold the last head value.
- Latency:
  - A record is pushed in the cycle its successor commits (or flush_i is asserted).
  - It is visible on the trace outputs one cycle later when the FIFO was empty.
- Reset mid-stream: all buffered and pending records are lost; no partial record appears after reset.

Decomposition:
- Shared package constants:
  - TRACE_REC_W = 81 (32 pc + 32 instr + 1 mispred + 16 seq)
  - Field offset constants for packing and unpacking the record
  - SEQ_W = 16
- Sub-module trace_fifo: DEPTH×TRACE_REC_W synchronous FIFO with push/pop/full/empty/count and async reset.
- The top level holds the pending stage, push/drop arbitration and the counters.

Test Plan:
- Commits PC 0x0 (pred 0x4), 0x4 (pred 0x8), 0x8, then flush, with ready = 1 → three records, seq 0,1,2, all mispred = 0; instret_o = 3; mispred_cnt_o = 0.
- Commit PC 0x10 with pred 0x14, then commit PC 0x40 → record pc = 0x10 has mispred = 1; mispred_cnt_o = 1.
- ready = 0; 10 commits then flush with DEPTH = 8 → fifo_count_o = 8; drop_cnt_o = 2; then ready = 1 drains seq 0..7 in order, with head fields stable while stalled.
- FIFO full, ready = 1 and a commit in the same cycle → push and pop both occur; count stays 8; drop_cnt_o unchanged.
- Assert rst asynchronously mid-cycle with 5 buffered records → trace_valid_o = 0 and all counters = 0 immediately; the next commit gets seq 0.
- clear_i in the same cycle as a commit whose push is a misprediction → all counters read 0 the next cycle; the FIFO still holds that record.
